// File: rtl/bask_pkg.sv
// ---------------------------------------------------------------------------
// bask_pkg
// Shared constants and types for the BASK receive path.
//   SAMPLE_W_DEF : default sample width (unsigned ADC/loopback samples)
//   SPS_DEF      : default samples per symbol
//   WORD_W_DEF   : default data bits per word (start symbol excluded)
//   bask_demod_state_t : demodulator FSM states
// ---------------------------------------------------------------------------
package bask_pkg;

    localparam int SAMPLE_W_DEF = 12;
    localparam int SPS_DEF      = 16;
    localparam int WORD_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } bask_demod_state_t;

endpackage

// File: rtl/bask_sym_integrator.sv
// ---------------------------------------------------------------------------
// bask_sym_integrator
// Integrates sample energy over one symbol period and slices it.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   sample_en  : the current din is accepted into the symbol
//   din        : unsigned sample
//   thresh     : decision threshold (acc >= thresh), used only at symbol end
//   sym_done   : combinational, high on the accepted last sample of a symbol
//   sym_bit    : combinational decision (acc + din) >= thresh
//   odd_nz     : accepted nonzero sample at an odd index (carrier gap
//                violation); tied 0 unless BASK_DEMOD_GAPCHK_EN is defined
// Optional feature macro: BASK_DEMOD_GAPCHK_EN
// ---------------------------------------------------------------------------
module bask_sym_integrator
    import bask_pkg::*;
#(
    parameter  int SPS      = SPS_DEF,
    parameter  int SAMPLE_W = SAMPLE_W_DEF,
    localparam int ACC_W    = SAMPLE_W + $clog2(SPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [SAMPLE_W-1:0] din,
    input  logic [ACC_W-1:0]    thresh,
    output logic                sym_done,
    output logic                sym_bit,
    output logic                odd_nz
);

    localparam int IDX_W = $clog2(SPS);

    logic [IDX_W-1:0] idx;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic             idx_last;

    assign idx_last = (idx == IDX_W'(SPS - 1));
    // ACC_W holds SPS full-scale samples, so acc + din can never wrap.
    assign acc_sum  = acc + ACC_W'(din);
    assign sym_done = sample_en && idx_last;
    assign sym_bit  = (acc_sum >= thresh);

`ifdef BASK_DEMOD_GAPCHK_EN
    assign odd_nz = sample_en && idx[0] && (din != '0);
`else
    assign odd_nz = 1'b0;
`endif

    // Accumulator restarts from zero at every symbol boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            acc <= '0;
        end else if (sample_en) begin
            if (idx_last) begin
                idx <= '0;
                acc <= '0;
            end else begin
                idx <= idx + 1'b1;
                acc <= acc_sum;
            end
        end
    end

endmodule

// File: rtl/bask_demod.sv
// ---------------------------------------------------------------------------
// bask_demod
// BASK demodulator: detects a start symbol, slices WORD_W data symbols by
// integrated energy against a runtime threshold and assembles LSB-first words.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   din         : unsigned sample;  din_valid : sample strobe
//   thresh      : decision threshold, acc >= thresh decides '1'
//   bit_out     : sliced data bit (held between pulses)
//   bit_valid   : one-cycle pulse per data bit
//   word_out    : assembled word, LSB = first data bit (held)
//   word_valid  : one-cycle pulse with the final bit_valid of a word
//   busy        : state != IDLE
//   gap_err     : odd-index nonzero sample seen in the word, presented with
//                 word_valid and held
// Optional feature macro: BASK_DEMOD_GAPCHK_EN (gap_err is 0 when undefined)
// ---------------------------------------------------------------------------
module bask_demod
    import bask_pkg::*;
#(
    parameter  int SPS      = SPS_DEF,
    parameter  int WORD_W   = WORD_W_DEF,
    parameter  int SAMPLE_W = SAMPLE_W_DEF,
    localparam int ACC_W    = SAMPLE_W + $clog2(SPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] din,
    input  logic                din_valid,
    input  logic [ACC_W-1:0]    thresh,
    output logic                bit_out,
    output logic                bit_valid,
    output logic [WORD_W-1:0]   word_out,
    output logic                word_valid,
    output logic                busy,
    output logic                gap_err
);

    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    bask_demod_state_t state, state_next;

    logic              sample_en;
    logic              start_entry;
    logic              last_bit;
    logic              sym_done;
    logic              sym_bit;
    logic              odd_nz;
    logic [BC_W-1:0]   bit_cnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shift_in;

    // In IDLE only a nonzero sample is consumed; it becomes index 0 of the
    // start symbol, so the integrator sees it in the same cycle.
    assign start_entry = (state == IDLE) && din_valid && (din != '0);
    assign sample_en   = din_valid && ((state != IDLE) || (din != '0));
    assign last_bit    = (state == DATA) && sym_done && (bit_cnt == BC_W'(WORD_W - 1));
    assign shift_in    = {sym_bit, shreg[WORD_W-1:1]};

    bask_sym_integrator #(
        .SPS      (SPS),
        .SAMPLE_W (SAMPLE_W)
    ) u_integ (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .din       (din),
        .thresh    (thresh),
        .sym_done  (sym_done),
        .sym_bit   (sym_bit),
        .odd_nz    (odd_nz)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start_entry) state_next = START;
            // A start symbol below threshold is treated as a glitch.
            START: if (sym_done)    state_next = sym_bit ? DATA : IDLE;
            DATA:  if (last_bit)    state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Decision stage: bit/word outputs registered one cycle after the
    // symbol's last sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            bit_valid  <= 1'b0;
            word_valid <= 1'b0;
            if ((state == START) && sym_done) begin
                bit_cnt <= '0;
            end
            if ((state == DATA) && sym_done) begin
                bit_out   <= sym_bit;
                bit_valid <= 1'b1;
                shreg     <= shift_in;
                bit_cnt   <= bit_cnt + 1'b1;
                if (last_bit) begin
                    word_out   <= shift_in;
                    word_valid <= 1'b1;
                    bit_cnt    <= '0;
                end
            end
        end
    end

`ifdef BASK_DEMOD_GAPCHK_EN
    logic gap_flag;

    // The symbol's last sample sits at an odd index, so it is folded in
    // directly when the word completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_flag <= 1'b0;
            gap_err  <= 1'b0;
        end else begin
            if (start_entry)  gap_flag <= 1'b0;
            else if (odd_nz)  gap_flag <= 1'b1;
            if (last_bit)     gap_err  <= gap_flag | odd_nz;
        end
    end
`else
    logic unused_odd_nz;
    assign unused_odd_nz = odd_nz;
    assign gap_err       = 1'b0;
`endif

endmodule
